// File: rtl/sram_mem_ctrl.sv
// sram_mem_ctrl
// Memory-stage controller placed after the EXE/MEM pipeline register. Each
// 32-bit load or store becomes two 16-bit SRAM transfers: low half first (LO),
// then high half (HI). Every phase lasts WAIT_CYCLES+1 cycles.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   Mem_R_En_In     load request
//   Mem_W_En_In     store request (wins when both enables are high)
//   ALU_Res_In      effective byte address
//   Val_Rm_In       store data
//   Ready           0 = freeze the earlier pipeline stages
//   Read_Data       last loaded word, registered
//   SRAM_*          registered SRAM pad controls / data, SRAM_DQ_In is the pad input
//
// Handshake: a request is accepted in IDLE whenever an enable is high. Ready
// stays low from that cycle until DONE. In DONE Ready is high and the pipeline
// advances, so the request seen in the following IDLE cycle is a new one.
module sram_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Mem_R_En_In,
    input  logic        Mem_W_En_In,
    input  logic [31:0] ALU_Res_In,
    input  logic [31:0] Val_Rm_In,
    output logic        Ready,
    output logic [31:0] Read_Data,
    output logic [17:0] SRAM_Addr,
    output logic [15:0] SRAM_DQ_Out,
    input  logic [15:0] SRAM_DQ_In,
    output logic        SRAM_DQ_OE,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [16:0] idx_q;      // captured SRAM word index
    logic [31:0] wdata_q;    // captured store data
    logic        wr_q;       // captured op type: 1 = store
    logic [15:0] rd_lo_q;    // low half staged until the high half arrives

    logic [31:0] offset;
    logic        req;
    logic        last_cyc;
    logic        unused_offset_bits;

    // Subtraction wraps mod 2^32; only the word index bits are kept.
    assign offset             = ALU_Res_In - BASE_ADDR;
    assign unused_offset_bits = ^{offset[31:19], offset[1:0]};
    assign req                = Mem_R_En_In | Mem_W_En_In;
    assign last_cyc           = (cnt == LAST_CNT);

    assign Ready = (state == DONE) || ((state == IDLE) && !req);

    // SRAM controls are loaded on the edge that enters each state, so they are
    // already valid during the first cycle of LO/HI.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 4'd0;
            idx_q       <= 17'd0;
            wdata_q     <= 32'd0;
            wr_q        <= 1'b0;
            rd_lo_q     <= 16'd0;
            Read_Data   <= 32'd0;
            SRAM_Addr   <= 18'd0;
            SRAM_DQ_Out <= 16'd0;
            SRAM_DQ_OE  <= 1'b0;
            SRAM_WE_N   <= 1'b1;
            SRAM_OE_N   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state      <= LO;
                        cnt        <= 4'd0;
                        idx_q      <= offset[18:2];
                        wdata_q    <= Val_Rm_In;
                        wr_q       <= Mem_W_En_In;
                        SRAM_Addr  <= {offset[18:2], 1'b0};
                        SRAM_DQ_OE <= Mem_W_En_In;
                        SRAM_WE_N  <= ~Mem_W_En_In;
                        SRAM_OE_N  <= Mem_W_En_In;
                        if (Mem_W_En_In) begin
                            SRAM_DQ_Out <= Val_Rm_In[15:0];
                        end
                    end
                end
                LO: begin
                    if (last_cyc) begin
                        state     <= HI;
                        cnt       <= 4'd0;
                        SRAM_Addr <= {idx_q, 1'b1};
                        if (wr_q) begin
                            SRAM_DQ_Out <= wdata_q[31:16];
                        end else begin
                            rd_lo_q <= SRAM_DQ_In;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                HI: begin
                    if (last_cyc) begin
                        state      <= DONE;
                        cnt        <= 4'd0;
                        SRAM_DQ_OE <= 1'b0;
                        SRAM_WE_N  <= 1'b1;
                        SRAM_OE_N  <= 1'b1;
                        // Whole word lands at once; no half-updated Read_Data.
                        if (!wr_q) begin
                            Read_Data <= {SRAM_DQ_In, rd_lo_q};
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
